// File: rtl/down_timer.sv
// Loadable down-counter with terminal pulse, optional auto-reload,
// and a sticky pending/overrun flag pair for the consumer.
module down_timer #(
  parameter int BIT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 load,
  input  logic [BIT_WIDTH-1:0] load_value,
  input  logic                 auto_reload,
  input  logic                 stop,
  input  logic                 ack,
  output logic [BIT_WIDTH-1:0] count,
  output logic                 busy,
  output logic                 done,
  output logic                 pending,
  output logic                 overrun
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [BIT_WIDTH-1:0] ONE = BIT_WIDTH'(1);

  logic [0:0]           state;
  logic [BIT_WIDTH-1:0] reload_reg;
  logic                 zero_load;
  logic                 at_term;
  logic                 term;

  assign busy = (state == RUN);

  assign zero_load = load && (load_value == '0);
  assign at_term = (state == RUN) && en && (count == ONE);

  // A zero-length load completes immediately and counts as a terminal event.
  assign term = load ? zero_load : (!stop && at_term);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      done       <= 1'b0;
      pending    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      done <= term;

      // Terminal wins over ack: ack consumes the older event only.
      if (term) begin
        pending <= 1'b1;
      end else if (ack) begin
        pending <= 1'b0;
      end

      if (load) begin
        count      <= load_value;
        reload_reg <= load_value;
        overrun    <= zero_load && pending && !ack;
        state      <= zero_load ? IDLE : RUN;
      end else if (stop) begin
        state <= IDLE;
      end else if ((state == RUN) && en) begin
        if (count == ONE) begin
          if (pending && !ack) begin
            overrun <= 1'b1;
          end
          if (auto_reload) begin
            count <= reload_reg;
          end else begin
            count <= '0;
            state <= IDLE;
          end
        end else begin
          count <= count - ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_down_timer.sv
// Scoreboard bench for down_timer: directed steps queue expected
// outputs, a negedge monitor pops and compares them.
module tb_down_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_value = '0;
  logic       auto_reload = 1'b0;
  logic       stop = 1'b0;
  logic       ack = 1'b0;
  logic [7:0] count;
  logic       busy;
  logic       done;
  logic       pending;
  logic       overrun;

  typedef struct packed {
    logic [7:0] count;
    logic       busy;
    logic       done;
    logic       pending;
    logic       overrun;
  } out_t;

  typedef struct {
    int   cyc;
    int   tid;
    out_t v;
  } exp_t;

  exp_t q[$];
  int   cyc_n = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   tid = 0;

  down_timer #(.BIT_WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .load(load),
    .load_value(load_value),
    .auto_reload(auto_reload),
    .stop(stop),
    .ack(ack),
    .count(count),
    .busy(busy),
    .done(done),
    .pending(pending),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Monitor: check every expectation that targets the edge just passed.
  initial begin
    exp_t e;
    out_t a;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc_n) begin
        e = q.pop_front();
        a = '{count, busy, done, pending, overrun};
        n_chk++;
        if (e.cyc != cyc_n || a !== e.v) begin
          n_fail++;
          $display("FAIL t%0d cyc%0d: got cnt=%0d busy=%b done=%b pend=%b ovr=%b, want cnt=%0d busy=%b done=%b pend=%b ovr=%b",
                   e.tid, e.cyc, a.count, a.busy, a.done, a.pending,
                   a.overrun, e.v.count, e.v.busy, e.v.done,
                   e.v.pending, e.v.overrun);
        end
      end
    end
  end

  // Queue outputs expected after the next posedge, then advance one cycle.
  task automatic chk(input logic [7:0] c, input logic b, input logic d,
                     input logic p, input logic o);
    exp_t e;
    e.cyc = cyc_n + 1;
    e.tid = tid;
    e.v   = '{c, b, d, p, o};
    q.push_back(e);
    @(negedge clk);
    #1;
    rst  = 1'b0;
    load = 1'b0;
    stop = 1'b0;
    ack  = 1'b0;
  endtask

  task automatic ld(input logic [7:0] n);
    load = 1'b1;
    load_value = n;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, want end of stimulus");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    #1;

    // T1: reset, single shot of 5
    tid = 1;
    rst = 1'b1;
    chk(0, 0, 0, 0, 0);
    en = 1'b1;
    ld(5);
    chk(5, 1, 0, 0, 0);
    chk(4, 1, 0, 0, 0);
    chk(3, 1, 0, 0, 0);
    chk(2, 1, 0, 0, 0);
    chk(1, 1, 0, 0, 0);
    chk(0, 0, 1, 1, 0);
    chk(0, 0, 0, 1, 0);
    ack = 1'b1;
    chk(0, 0, 0, 0, 0);

    // T2: auto-reload of 3, overrun on second terminal
    tid = 2;
    auto_reload = 1'b1;
    ld(3);
    chk(3, 1, 0, 0, 0);
    chk(2, 1, 0, 0, 0);
    chk(1, 1, 0, 0, 0);
    chk(3, 1, 1, 1, 0);
    chk(2, 1, 0, 1, 0);
    chk(1, 1, 0, 1, 0);
    chk(3, 1, 1, 1, 1);
    ack = 1'b1;
    chk(2, 1, 0, 0, 1);
    ld(3);
    chk(3, 1, 0, 0, 0);
    stop = 1'b1;
    chk(3, 0, 0, 0, 0);

    // T3: en toggling, count holds on en=0
    tid = 3;
    auto_reload = 1'b0;
    ld(4);
    chk(4, 1, 0, 0, 0);
    for (int i = 3; i >= 1; i--) begin
      en = 1'b1;
      chk(8'(i), 1, 0, 0, 0);
      en = 1'b0;
      chk(8'(i), 1, 0, 0, 0);
    end
    en = 1'b1;
    chk(0, 0, 1, 1, 0);
    en = 1'b0;
    chk(0, 0, 0, 1, 0);
    ack = 1'b1;
    chk(0, 0, 0, 0, 0);

    // T4: zero load, then restart mid-run
    tid = 4;
    en = 1'b1;
    ld(0);
    chk(0, 0, 1, 1, 0);
    ack = 1'b1;
    chk(0, 0, 0, 0, 0);
    ld(5);
    chk(5, 1, 0, 0, 0);
    chk(4, 1, 0, 0, 0);
    chk(3, 1, 0, 0, 0);
    chk(2, 1, 0, 0, 0);
    ld(7);
    chk(7, 1, 0, 0, 0);
    chk(6, 1, 0, 0, 0);
    stop = 1'b1;
    chk(6, 0, 0, 0, 0);

    // T5: stop holds count; rst beats load mid-run
    tid = 5;
    ld(5);
    chk(5, 1, 0, 0, 0);
    chk(4, 1, 0, 0, 0);
    chk(3, 1, 0, 0, 0);
    stop = 1'b1;
    chk(3, 0, 0, 0, 0);
    chk(3, 0, 0, 0, 0);
    ld(1);
    chk(1, 1, 0, 0, 0);
    chk(0, 0, 1, 1, 0);
    auto_reload = 1'b1;
    ld(2);
    chk(2, 1, 0, 1, 0);
    chk(1, 1, 0, 1, 0);
    chk(2, 1, 1, 1, 1);
    rst = 1'b1;
    ld(5);
    chk(0, 0, 0, 0, 0);

    // T6: terminal with ack; N=1 with auto-reload
    tid = 6;
    auto_reload = 1'b0;
    ld(2);
    chk(2, 1, 0, 0, 0);
    chk(1, 1, 0, 0, 0);
    chk(0, 0, 1, 1, 0);
    ld(2);
    chk(2, 1, 0, 1, 0);
    chk(1, 1, 0, 1, 0);
    ack = 1'b1;
    chk(0, 0, 1, 1, 0);
    auto_reload = 1'b1;
    ld(1);
    chk(1, 1, 0, 1, 0);
    ack = 1'b1;
    chk(1, 1, 1, 1, 0);
    chk(1, 1, 1, 1, 1);
    en = 1'b0;
    chk(1, 1, 0, 1, 1);
    en = 1'b1;
    chk(1, 1, 1, 1, 1);
    stop = 1'b1;
    chk(1, 0, 0, 1, 1);
    rst = 1'b1;
    chk(0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d entries left, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
